// File: rtl/vector_checker_pkg.sv
// Shared types and sizing constants for the vector sweep checker and its timer.
package vector_checker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam int N_VEC = 16;
    localparam int VEC_W = 4;
    localparam int CNT_W = 8;

    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(N_VEC - 1);

endpackage

// File: rtl/vector_checker_settle_timer.sv
// Loadable up-counter that raises tc_o on the last cycle of a SETTLE_CYCLES window.
module settle_timer
    import vector_checker_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: load restarts the window, enable advances it.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = en_i && (count_q == TC_VAL);

endmodule

// File: rtl/vector_checker.sv
// Sweeps all 16 {a,b,c,d} vectors into a unit under test, samples x per vector and
// compares the observed truth table against EXPECTED.
module vector_checker
    import vector_checker_pkg::*;
#(
    parameter logic [15:0] EXPECTED      = 16'h0000,
    parameter int          SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        x,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] result,
    output logic [4:0]  fail_count,
    output logic [3:0]  first_fail,
    output logic        first_fail_valid
);

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   idx_q, idx_d;
    logic [N_VEC-1:0]   result_q, result_d;
    logic [4:0]         fail_q, fail_d;
    logic [VEC_W-1:0]   ff_q, ff_d;
    logic               ffv_q, ffv_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               timer_load_s;
    logic               tc_s;

    settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (timer_load_s),
        .en_i   (state_q == SETTLE),
        .tc_o   (tc_s)
    );

    // Sweep sequencing, sampling and mismatch bookkeeping.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        result_d     = result_q;
        fail_d       = fail_q;
        ff_d         = ff_q;
        ffv_d        = ffv_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        timer_load_s = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = SETTLE;
                    idx_d        = '0;
                    result_d     = '0;
                    fail_d       = 5'd0;
                    ff_d         = '0;
                    ffv_d        = 1'b0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    timer_load_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            SETTLE: begin
                if (tc_s) begin
                    timer_load_s    = 1'b1;
                    result_d[idx_q] = x;
                    if (x != EXPECTED[idx_q]) begin
                        fail_d = fail_q + 5'd1;
                        if (!ffv_q) begin
                            ff_d  = idx_q;
                            ffv_d = 1'b1;
                        end else begin
                            ff_d = ff_q;
                        end
                    end else begin
                        fail_d = fail_q;
                    end
                    // Explicit compare against the last index; idx never wraps.
                    if (idx_q == LAST_VEC) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (fail_d == 5'd0);
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    state_d = SETTLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            result_q <= '0;
            fail_q   <= 5'd0;
            ff_q     <= '0;
            ffv_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            fail_q   <= fail_d;
            ff_q     <= ff_d;
            ffv_q    <= ffv_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign {a, b, c, d}     = idx_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign result           = result_q;
    assign fail_count       = fail_q;
    assign first_fail       = ff_q;
    assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_vector_checker.sv
// Scoreboard bench: two checkers (4-cycle and 1-cycle settle) driving a behavioural unit under test.
module tb_vector_checker;

    localparam logic [15:0] EXP = 16'hF888;
    localparam int S4 = 4;
    localparam int S1 = 1;

    typedef struct packed {
        logic [15:0] result;
        logic [4:0]  fail_count;
        logic [3:0]  first_fail;
        logic        ffv;
        logic        pass;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4, start4, x4, a4, b4, c4, d4, busy4, done4, pass4, ffv4;
    logic rst1, start1, x1, a1, b1, c1, d1, busy1, done1, pass1, ffv1;
    logic [15:0] res4, res1;
    logic [4:0]  fc4, fc1;
    logic [3:0]  ff4, ff1;

    int mode4 = 0, fv4 = 0, mode1 = 0, fv1 = 0;
    logic [15:0] tt4 = 16'h0000, tt1 = 16'h0000;

    int n_checks = 0, n_pass = 0;
    int cyc = 0;
    int npop4 = 0, npop1 = 0;
    exp_t q4[$], q1[$];
    int sc4[$], sc1[$];
    logic pd4 = 1'b0, pd1 = 1'b0;

    // Unit under test: 0 correct, 1 inverted at vector fv, 2 stuck 0, 3 stuck 1, else table tt.
    function automatic logic uut(int mode, int fv, logic [15:0] tt, logic [3:0] v);
        logic good;
        good = (v[3] & v[2]) | (v[1] & v[0]);
        case (mode)
            0:       return good;
            1:       return good ^ (32'(v) == fv);
            2:       return 1'b0;
            3:       return 1'b1;
            default: return tt[v];
        endcase
    endfunction

    // Reference: build the observed table and compare it to EXP bit by bit.
    function automatic exp_t model(int mode, int fv, logic [15:0] tt);
        exp_t e;
        logic o;
        e = '0;
        for (int i = 0; i < 16; i++) begin
            o = uut(mode, fv, tt, 4'(i));
            e.result[i] = o;
            if (o != EXP[i]) begin
                if (!e.ffv) begin
                    e.ffv = 1'b1;
                    e.first_fail = 4'(i);
                end
                e.fail_count = e.fail_count + 5'd1;
            end
        end
        e.pass = (e.fail_count == 5'd0);
        return e;
    endfunction

    assign x4 = uut(mode4, fv4, tt4, {a4, b4, c4, d4});
    assign x1 = uut(mode1, fv1, tt1, {a1, b1, c1, d1});

    vector_checker #(.EXPECTED(EXP), .SETTLE_CYCLES(S4)) u_dut4 (
        .clk(clk), .rst(rst4), .start(start4), .x(x4),
        .a(a4), .b(b4), .c(c4), .d(d4), .busy(busy4), .done(done4), .pass(pass4),
        .result(res4), .fail_count(fc4), .first_fail(ff4), .first_fail_valid(ffv4)
    );

    vector_checker #(.EXPECTED(EXP), .SETTLE_CYCLES(S1)) u_dut1 (
        .clk(clk), .rst(rst1), .start(start1), .x(x1),
        .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1), .pass(pass1),
        .result(res1), .fail_count(fc1), .first_fail(ff1), .first_fail_valid(ffv1)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic mon_check(string tag, exp_t e, int scyc, int s, logic [15:0] res,
                             logic [4:0] fc, logic [3:0] ff, logic ffv, logic ps, logic bsy);
        check({tag, "_result"}, 32'(res), 32'(e.result));
        check({tag, "_fail_count"}, 32'(fc), 32'(e.fail_count));
        check({tag, "_first_fail"}, 32'(ff), 32'(e.first_fail));
        check({tag, "_first_fail_valid"}, 32'(ffv), 32'(e.ffv));
        check({tag, "_pass"}, 32'(ps), 32'(e.pass));
        check({tag, "_busy_at_done"}, 32'(bsy), 32'd0);
        check({tag, "_latency"}, 32'(cyc - scyc), 32'(16 * s));
    endtask

    // Monitor for the 4-cycle checker: score each rising done.
    always @(negedge clk) begin
        if (done4 && !pd4) begin
            if (q4.size() == 0) begin
                check("dut4_unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_check("dut4", q4.pop_front(), sc4.pop_front(), S4,
                          res4, fc4, ff4, ffv4, pass4, busy4);
                npop4 <= npop4 + 1;
            end
        end
        pd4 <= done4;
    end

    // Monitor for the 1-cycle checker.
    always @(negedge clk) begin
        if (done1 && !pd1) begin
            if (q1.size() == 0) begin
                check("dut1_unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_check("dut1", q1.pop_front(), sc1.pop_front(), S1,
                          res1, fc1, ff1, ffv1, pass1, busy1);
                npop1 <= npop1 + 1;
            end
        end
        pd1 <= done1;
    end

    // Cycle counter: value at a negedge is the index of the preceding rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_pop(int inst, int target, int lim);
        int got;
        got = (inst == 1) ? npop1 : npop4;
        for (int i = 0; i < lim && got < target; i++) begin
            @(negedge clk);
            got = (inst == 1) ? npop1 : npop4;
        end
        check((inst == 1) ? "dut1_done_timeout" : "dut4_done_timeout", 32'(got >= target), 32'd1);
    endtask

    task automatic issue(int inst, int mode, int fv, logic [15:0] tt);
        if (inst == 1) begin
            mode1 = mode; fv1 = fv; tt1 = tt; start1 = 1'b1;
            q1.push_back(model(mode, fv, tt)); sc1.push_back(cyc + 1);
        end else begin
            mode4 = mode; fv4 = fv; tt4 = tt; start4 = 1'b1;
            q4.push_back(model(mode, fv, tt)); sc4.push_back(cyc + 1);
        end
    endtask

    task automatic sweep(int inst, int mode, int fv, logic [15:0] tt);
        int target;
        target = ((inst == 1) ? npop1 : npop4) + 1;
        @(negedge clk);
        issue(inst, mode, fv, tt);
        @(negedge clk);
        start1 = 1'b0; start4 = 1'b0;
        wait_pop(inst, target, 16 * ((inst == 1) ? S1 : S4) + 10);
    endtask

    task automatic check_reset4(string tag);
        check({tag, "_vec"}, 32'({a4, b4, c4, d4}), 32'd0);
        check({tag, "_busy"}, 32'(busy4), 32'd0);
        check({tag, "_done"}, 32'(done4), 32'd0);
        check({tag, "_pass"}, 32'(pass4), 32'd0);
        check({tag, "_result"}, 32'(res4), 32'd0);
        check({tag, "_fail_count"}, 32'(fc4), 32'd0);
        check({tag, "_first_fail"}, 32'({ff4, ffv4}), 32'd0);
    endtask

    initial begin
        int k, target;
        rst4 = 1'b1; rst1 = 1'b1; start4 = 1'b0; start1 = 1'b0;
        repeat (3) @(negedge clk);
        check_reset4("reset4");
        check("reset1_outputs", 32'({a1, b1, c1, d1, busy1, done1, pass1, ffv1, fc1}), 32'd0);
        rst4 = 1'b0; rst1 = 1'b0;
        @(negedge clk);

        // Directed cases from the plan on the 4-cycle checker.
        sweep(4, 0, 0, 16'h0000);
        sweep(4, 1, 5, 16'h0000);
        sweep(4, 2, 0, 16'h0000);
        sweep(4, 3, 0, 16'h0000);
        repeat (3) @(negedge clk);
        check("dut4_done_level_held", 32'({done4, busy4}), 32'b10);

        // Reset while vector 9 is driven, then a clean sweep.
        @(negedge clk);
        issue(4, 0, 0, 16'h0000);
        @(negedge clk);
        start4 = 1'b0;
        for (int i = 0; i < 200 && {a4, b4, c4, d4} != 4'd9; i++) @(negedge clk);
        check("dut4_reach_vec9", 32'({a4, b4, c4, d4}), 32'd9);
        rst4 = 1'b1;
        void'(q4.pop_back());
        void'(sc4.pop_back());
        @(negedge clk);
        rst4 = 1'b0;
        check_reset4("midsweep_reset");
        repeat (3) @(negedge clk);
        check("idle_after_reset_busy", 32'({busy4, done4}), 32'd0);
        sweep(4, 0, 0, 16'h0000);

        // 1-cycle checker: basic timing, then start ignored at vector 7.
        sweep(1, 0, 0, 16'h0000);
        target = npop1 + 1;
        @(negedge clk);
        issue(1, 1, 11, 16'h0000);
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 40 && {a1, b1, c1, d1} != 4'd7; i++) @(negedge clk);
        check("dut1_reach_vec7", 32'({a1, b1, c1, d1}), 32'd7);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_pop(1, target, 40);

        // Start held high: back-to-back sweeps, results cleared each time.
        repeat (2) @(negedge clk);
        target = npop1 + 3;
        k = cyc + 1;
        issue(1, 3, 0, 16'h0000);
        q1.push_back(model(3, 0, 16'h0000)); sc1.push_back(k + 17);
        q1.push_back(model(3, 0, 16'h0000)); sc1.push_back(k + 34);
        while (cyc < k + 34 + 16 * S1) @(negedge clk);
        start1 = 1'b0;
        wait_pop(1, target, 20);
        repeat (3) @(negedge clk);
        check("dut1_stays_done", 32'({done1, busy1}), 32'b10);

        // Randomised sweeps on both checkers.
        for (int n = 0; n < 6; n++) begin
            sweep(4, int'($urandom_range(0, 4)), int'($urandom_range(0, 15)), 16'($urandom));
            sweep(1, int'($urandom_range(0, 4)), int'($urandom_range(0, 15)), 16'($urandom));
        end

        repeat (5) @(negedge clk);
        check("dut4_queue_drained", 32'(q4.size()), 32'd0);
        check("dut1_queue_drained", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vector_checker.md
Name: vector_checker

Overview:
- Sequential stimulus/response engine for the 4-input combinational lab blocks: the hardware-side counterpart of a vector sweep.
- Drives all 16 input combinations {a,b,c,d} into a unit under test, holds each for a settle window and samples the single-bit response x.
- Assembles a 16-bit observed truth table, compares it bit-by-bit against an expected table and reports pass/fail, mismatch count and the first failing vector.
- Sits between board controls (start button/LEDs) and the combinational module under test.

Parameters:
- EXPECTED, 16'h0000, expected truth table; bit i = required x when {a,b,c,d} == i (a is MSB).
- SETTLE_CYCLES, 4, clock cycles each vector is held; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin sweep; sampled only in IDLE or DONE.
- x  input  1  response from unit under test.
- a  output  1  stimulus bit 3 (MSB).
- b  output  1  stimulus bit 2.
- c  output  1  stimulus bit 1.
- d  output  1  stimulus bit 0 (LSB).
- busy  output  1  sweep in progress.
- done  output  1  sweep complete; level, held until next start or rst.
- pass  output  1  valid when done: 1 iff fail_count == 0.
- result  output  16  observed truth table, bit i = sampled x for vector i.
- fail_count  output  5  number of mismatching vectors, 0..16.
- first_fail  output  4  lowest index that mismatched.
- first_fail_valid  output  1  at least one mismatch recorded.

Behaviour:
- One clock; reset is synchronous and active-high (ports clk, rst). All state changes occur on the rising clk edge.
- Reset values: {a,b,c,d}=0, busy=0, done=0, pass=0, result=0, fail_count=0, first_fail=0, first_fail_valid=0. State returns to IDLE.
- States: IDLE, SETTLE, DONE.
- IDLE or DONE with start=1:
  - Next state is SETTLE; idx=0 is driven on {a,b,c,d}.
  - result, fail_count, first_fail and first_fail_valid clear to 0; done=0; busy=1.
- SETTLE:
  - The settle counter runs 0..SETTLE_CYCLES-1.
  - On the edge where count == SETTLE_CYCLES-1:
    - Sample x into result[idx].
    - If x != EXPECTED[idx], increment fail_count.
    - If that mismatch is the first one, set first_fail=idx and first_fail_valid=1.
  - On that same edge: if idx<15, increment idx (drive the new vector) and reset the count; if idx==15, go to DONE.
- Timing: each vector is held exactly SETTLE_CYCLES cycles.
  - start sampled at edge k: vector 0 is visible after edge k.
  - Vector i is sampled at edge k+(i+1)*SETTLE_CYCLES.
  - done=1 and busy=0 after edge k+16*SETTLE_CYCLES.
- DONE:
  - {a,b,c,d} holds 15.
  - pass = (fail_count == 0) and is registered together with done.
  - Outputs are stable until the next start.
- start during SETTLE is ignored (no restart, no queueing).
- start held high continuously: a new sweep launches on the first DONE cycle, so done is high for exactly one cycle per sweep.
- rst mid-sweep aborts immediately to the reset values. No partial results are retained.
- x is assumed synchronous to clk (on-chip unit under test). No synchroniser.
- fail_count is 5 bits so that 16 mismatches do not wrap. idx is 4 bits; the exit test is idx==15 and must not depend on wrap-around.

Decomposition:
- Shared package (vector_checker_pkg):
  - state enum {IDLE, SETTLE, DONE};
  - N_VEC=16, VEC_W=4, CNT_W=8.
- One sub-module: settle_timer.
  - Loadable down/up counter with a terminal-count pulse, parameterised by SETTLE_CYCLES.
  - Reused for the display/debounce blocks.
- Everything else stays in vector_checker.

Test Plan:
- Correct unit under test x=(a&b)|(c&d), EXPECTED=16'hF888, SETTLE_CYCLES=4, start pulse at cycle 2 -> busy for 64 cycles; done=1, pass=1, result=16'hF888, fail_count=0, first_fail_valid=0.
- Same unit under test, but x inverted while vector==5 -> result=16'hF8A8, fail_count=1, first_fail=5, first_fail_valid=1, pass=0.
- x stuck at 0 -> result=16'h0000, fail_count=7, first_fail=3, pass=0. x stuck at 1 -> result=16'hFFFF, fail_count=9, first_fail=0.
- SETTLE_CYCLES=1, check timing -> each vector held 1 cycle, done exactly 16 cycles after the start edge. start pulsed at vector 7 is ignored; start held high -> done high 1 cycle, then the sweep restarts with cleared results.
- rst asserted while vector 9 is driven -> next cycle all outputs are at reset values and the state is IDLE. A later start produces a full correct sweep (result=16'hF888, pass=1).
